// File: rtl/comm_pkg.sv
// Shared types and constants for the UART word serializer.
package comm_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam logic [BYTE_W-1:0] DEFAULT_HEADER_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_e;

endpackage

// File: rtl/tx_word_serializer_if.sv
// Buffer-side and UART-side handshake bundle of the word serializer.
interface tx_word_serializer_if #(
    parameter int unsigned WORD_BYTES = 16
);
    import comm_pkg::*;

    logic [WORD_BYTES*BYTE_W-1:0] din;
    logic                         buffer_empty;
    logic                         buffer_read;
    logic                         tx_done;
    logic                         tx_start;
    logic [BYTE_W-1:0]            dout;
    logic                         abort;
    logic                         busy;
    logic                         word_done;

    modport master (
        input  din, buffer_empty, tx_done, abort,
        output buffer_read, tx_start, dout, busy, word_done
    );

    modport slave (
        output din, buffer_empty, tx_done, abort,
        input  buffer_read, tx_start, dout, busy, word_done
    );

endinterface

// File: rtl/tx_byte_shifter.sv
// Word shift register that hands out one byte at a time, MSB- or LSB-first.
// head is the byte at the front of the register as it will be after this edge.
module tx_byte_shifter
    import comm_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 16,
    parameter int unsigned MSB_FIRST  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic                         shift,
    input  logic [WORD_BYTES*BYTE_W-1:0] din,
    output logic [BYTE_W-1:0]            head
);

    localparam int unsigned WORD_W = WORD_BYTES * BYTE_W;

    logic [WORD_W-1:0] sr_q;
    logic [WORD_W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = (MSB_FIRST != 0) ? (sr_q << BYTE_W) : (sr_q >> BYTE_W);
        end
    end

    // Look-ahead head lets the caller register dout in the same edge as the load/shift
    assign head = (MSB_FIRST != 0) ? sr_d[WORD_W-1 -: BYTE_W] : sr_d[BYTE_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/tx_word_serializer.sv
// Pops a wide word from the result buffer and streams it byte-wise to the UART,
// with optional header byte, selectable byte order and abort.
module tx_word_serializer
    import comm_pkg::*;
#(
    parameter int unsigned       WORD_BYTES  = 16,
    parameter int unsigned       MSB_FIRST   = 1,
    parameter int unsigned       HEADER_EN   = 0,
    parameter logic [BYTE_W-1:0] HEADER_BYTE = DEFAULT_HEADER_BYTE
) (
    input logic                  clk,
    input logic                  reset,
    tx_word_serializer_if.master bus
);

    localparam int unsigned HDR         = (HEADER_EN != 0) ? 1 : 0;
    localparam int unsigned FRAME_BYTES = WORD_BYTES + HDR;
    localparam int unsigned CTR_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [CTR_W-1:0] LAST_CTR = CTR_W'(FRAME_BYTES - 1);

    state_e            state_q, state_d;
    logic [CTR_W-1:0]  ctr_q, ctr_d;
    logic              tx_start_q, tx_start_d;
    logic              word_done_q, word_done_d;
    logic              busy_q, busy_d;
    logic [BYTE_W-1:0] dout_q, byte_d;
    logic              buf_read;
    logic              load, shift;
    logic              hdr_now;
    logic [BYTE_W-1:0] head;

    tx_byte_shifter #(
        .WORD_BYTES (WORD_BYTES),
        .MSB_FIRST  (MSB_FIRST)
    ) u_shifter (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (bus.din),
        .head  (head)
    );

    assign hdr_now = (HDR != 0) && (ctr_q == '0);

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        load        = 1'b0;
        shift       = 1'b0;
        buf_read    = 1'b0;
        word_done_d = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
            ctr_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // word_done_q holds off the pop so a new word starts two cycles after the last tx_done
                    if (!bus.buffer_empty && !word_done_q && !reset) begin
                        buf_read = 1'b1;
                        state_d  = LOAD;
                    end
                end
                LOAD: begin
                    load    = 1'b1;
                    ctr_d   = '0;
                    state_d = START;
                end
                START: state_d = WAIT;
                WAIT: begin
                    if (bus.tx_done) begin
                        if (ctr_q == LAST_CTR) begin
                            word_done_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            ctr_d   = ctr_q + CTR_W'(1);
                            shift   = !hdr_now;
                            state_d = START;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        tx_start_d = (state_d == START);
        busy_d     = (state_d != IDLE);
        byte_d     = ((HDR != 0) && (ctr_d == '0)) ? HEADER_BYTE : head;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ctr_q       <= '0;
            tx_start_q  <= 1'b0;
            word_done_q <= 1'b0;
            busy_q      <= 1'b0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            tx_start_q  <= tx_start_d;
            word_done_q <= word_done_d;
            busy_q      <= busy_d;
            if (tx_start_d) begin
                dout_q <= byte_d;
            end
        end
    end

    assign bus.buffer_read = buf_read;
    assign bus.tx_start    = tx_start_q;
    assign bus.word_done   = word_done_q;
    assign bus.busy        = busy_q;
    assign bus.dout        = dout_q;

endmodule

// File: tb/tb_tx_word_serializer.sv
// Scoreboard bench for tx_word_serializer: three configurations driven one at a time.
module tb_tx_word_serializer;
    import comm_pkg::*;

    localparam logic [127:0] W0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] W1 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    localparam logic [127:0] W2 = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
    localparam logic [127:0] W3 = 128'h00000000_00000000_00000000_CAFEF00D;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tx_word_serializer_if #(.WORD_BYTES(16)) if0 ();
    tx_word_serializer_if #(.WORD_BYTES(16)) if1 ();
    tx_word_serializer_if #(.WORD_BYTES(4))  if2 ();

    tx_word_serializer u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    tx_word_serializer #(.WORD_BYTES(16), .MSB_FIRST(0), .HEADER_EN(1))
        u_dut1 (.clk(clk), .reset(reset), .bus(if1));
    tx_word_serializer #(.WORD_BYTES(4))
        u_dut2 (.clk(clk), .reset(reset), .bus(if2));

    int           sel = 0;
    int           pushed = 0;
    int           popped = 0;
    logic [127:0] din_reg = '0;
    logic         done_r = 1'b0;
    logic         stray_r = 1'b0;
    logic         abort_r = 1'b0;
    logic         buf_empty;

    logic [127:0] wq[$];
    logic [7:0]   exp_q[$];

    int n_checks = 0, n_err = 0;
    int cyc = 0, fbytes = 0, words_done = 0, reads = 0;
    int rd_cyc = 0, prev_ts = 0, final_cyc = -100, done_at = 0;
    bit pending = 1'b0;
    bit hit;
    int wd0;

    assign buf_empty = (pushed == popped);

    assign if0.din = din_reg;
    assign if1.din = din_reg;
    assign if2.din = din_reg[31:0];
    assign if0.buffer_empty = buf_empty || (sel != 0);
    assign if1.buffer_empty = buf_empty || (sel != 1);
    assign if2.buffer_empty = buf_empty || (sel != 2);
    assign if0.tx_done = (sel == 0) && (done_r || stray_r);
    assign if1.tx_done = (sel == 1) && (done_r || stray_r);
    assign if2.tx_done = (sel == 2) && (done_r || stray_r);
    assign if0.abort = (sel == 0) && abort_r;
    assign if1.abort = (sel == 1) && abort_r;
    assign if2.abort = (sel == 2) && abort_r;

    logic       m_bread, m_tstart, m_wdone, m_busy;
    logic [7:0] m_dout;

    always_comb begin
        m_bread  = if0.buffer_read;
        m_tstart = if0.tx_start;
        m_wdone  = if0.word_done;
        m_busy   = if0.busy;
        m_dout   = if0.dout;
        case (sel)
            1: begin
                m_bread = if1.buffer_read; m_tstart = if1.tx_start;
                m_wdone = if1.word_done;   m_busy = if1.busy; m_dout = if1.dout;
            end
            2: begin
                m_bread = if2.buffer_read; m_tstart = if2.tx_start;
                m_wdone = if2.word_done;   m_busy = if2.busy; m_dout = if2.dout;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int flen(input int s);
        return (s == 0) ? 16 : ((s == 1) ? 17 : 4);
    endfunction

    function automatic int dly(input int s);
        return (s == 2) ? 1 : 10;
    endfunction

    // Queue a word for the buffer and the bytes the active configuration must emit for it
    task automatic push_word(input logic [127:0] w);
        int wb;
        bit msb;
        wb  = (sel == 2) ? 4 : 16;
        msb = (sel != 1);
        if (sel == 1) exp_q.push_back(8'hA5);
        for (int i = 0; i < wb; i++) begin
            int idx;
            idx = msb ? (wb - 1 - i) : i;
            exp_q.push_back(w[8*idx +: 8]);
        end
        wq.push_back(w);
        pushed++;
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 3000 && words_done < n; i++) @(negedge clk);
        chk("words_done", words_done, n);
    endtask

    // Buffer, UART and scoreboard model; reads pre-edge DUT values like a flop
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            fbytes  = 0;
            pending = 1'b0;
            done_r <= 1'b0;
        end else begin
            if (abort_r) begin
                exp_q.delete();
                fbytes  = 0;
                pending = 1'b0;
            end else if (done_r && fbytes == flen(sel)) begin
                final_cyc = cyc;
            end
            if (m_bread) begin
                reads++;
                chk("rd_gap", (cyc - final_cyc) >= 2, 1);
                rd_cyc = cyc;
                if (wq.size() != 0) din_reg <= wq.pop_front();
                popped <= popped + 1;
            end
            if (m_tstart) begin
                if (fbytes == 0) chk("first_lat", cyc - rd_cyc, 2);
                else             chk("byte_period", cyc - prev_ts, dly(sel) + 1);
                chk("exp_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("byte", m_dout, exp_q.pop_front());
                prev_ts = cyc;
                fbytes++;
                pending = 1'b1;
                done_at = cyc + dly(sel);
            end
            if (m_wdone) begin
                chk("wd_latency", cyc - final_cyc, 1);
                chk("frame_len", fbytes, flen(sel));
                fbytes = 0;
                words_done++;
            end
            if (pending && (cyc + 1 == done_at)) begin
                done_r <= 1'b1;
                pending = 1'b0;
            end else begin
                done_r <= 1'b0;
            end
        end
        cyc++;
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", if0.busy, 0);
        chk("rst_tstart", if0.tx_start, 0);
        chk("rst_wdone", if0.word_done, 0);
        chk("rst_bread", if0.buffer_read, 0);
        chk("rst_dout", if0.dout, 0);
        chk("rst_dout_hdr", if1.dout, 0);
        reset = 1'b0;
        @(negedge clk);

        // default config, single word
        sel = 0;
        push_word(W0);
        wait_words(1);
        chk("t1_reads", reads, 1);
        chk("t1_exp_empty", exp_q.size(), 0);

        // LSB-first with header
        sel = 1;
        push_word(W0);
        wait_words(2);
        chk("t2_reads", reads, 2);

        // two words back-to-back
        sel = 0;
        push_word(W1);
        push_word(W2);
        wait_words(4);
        chk("t3_reads", reads, 4);
        chk("t3_exp_empty", exp_q.size(), 0);

        // abort coinciding with tx_done of byte 5
        push_word(W0);
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            hit = (fbytes == 5) && done_r;
        end
        chk("abort_sync", hit, 1);
        abort_r = 1'b1;
        @(negedge clk);
        abort_r = 1'b0;
        chk("abort_idle_busy", m_busy, 0);
        chk("abort_no_wd", m_wdone, 0);
        wd0 = words_done;
        repeat (20) @(negedge clk);
        chk("abort_no_wd_later", words_done, wd0);
        chk("abort_flushed", exp_q.size(), 0);
        push_word(W1);
        wait_words(wd0 + 1);

        // asynchronous reset mid-frame
        push_word(W0);
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            hit = (fbytes == 3);
        end
        chk("reset_sync", hit, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", m_busy, 0);
        chk("arst_tstart", m_tstart, 0);
        chk("arst_dout", m_dout, 0);
        chk("arst_wdone", m_wdone, 0);
        chk("arst_bread", m_bread, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("arst_flushed", exp_q.size(), 0);

        // stray tx_done in IDLE and in START must not advance the byte counter
        @(negedge clk);
        stray_r = 1'b1;
        @(negedge clk);
        stray_r = 1'b0;
        chk("stray_idle_busy", m_busy, 0);
        wd0 = words_done;
        push_word(W2);
        for (int k = 0; k < 2; k++) begin
            hit = 1'b0;
            for (int i = 0; i < 400 && !hit; i++) begin
                @(negedge clk);
                hit = m_tstart && (fbytes == k);
            end
            chk("stray_start_sync", hit, 1);
            stray_r = 1'b1;
            @(negedge clk);
            stray_r = 1'b0;
        end
        wait_words(wd0 + 1);
        chk("t5_exp_empty", exp_q.size(), 0);

        // 4-byte word with 1-cycle UART
        sel = 2;
        wd0 = words_done;
        push_word(W3);
        wait_words(wd0 + 1);
        repeat (5) @(negedge clk);
        chk("t6_single_wd", words_done, wd0 + 1);
        chk("final_reads", reads, 9);
        chk("final_exp_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
